// File: rtl/clken_nco_gen.sv
// clken_nco_gen: multi-channel NCO clock-enable generator with settle/lock sequencing.
//
// Purpose
//   Each channel runs an ACC_W-bit phase accumulator. Its increment register sets
//   the mean pulse rate, f_refclk * inc / 2^ACC_W. The channel's clken bit is the
//   registered carry out of the accumulator sum. All accumulators are cleared on
//   the same cycle, so the channels stay phase-aligned.
//
//   After run rises, or after any accepted increment write while running, the block
//   spends LOCK_CYCLES cycles in SETTLE. It then reports locked in LOCKED.
//
// Optional feature
//   CLKEN_LOCK_GATE_EN : when defined, clken is held low in every state except
//                        LOCKED. The accumulators still run during SETTLE.
//
// Ports
//   refclk   in   1         sole clock, rising edge
//   rst      in   1         synchronous active-high reset
//   run      in   1         high requests generation, low forces IDLE
//   inc_wr   in   1         single-cycle increment write strobe
//   inc_sel  in   4         channel index for inc_wr (>= CHANNELS is ignored)
//   inc_data in   ACC_W     increment value written
//   clken    out  CHANNELS  registered one-cycle enable pulses, bit i = channel i
//   locked   out  1         registered, high only in state LOCKED
module clken_nco_gen #(
    parameter int CHANNELS    = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                run,
    input  logic                inc_wr,
    input  logic [3:0]          inc_sel,
    input  logic [ACC_W-1:0]    inc_data,
    output logic [CHANNELS-1:0] clken,
    output logic                locked
);
    localparam int CW = $clog2(LOCK_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic [ACC_W-1:0]    r_acc [CHANNELS];
    logic [ACC_W-1:0]    r_inc [CHANNELS];
    logic [ACC_W-1:0]    w_sum [CHANNELS];
    logic [CHANNELS-1:0] w_carry, w_clken_next, r_clken;
    logic                r_locked, w_wr_ok, w_clear;

    assign w_wr_ok = inc_wr && (32'(inc_sel) < CHANNELS);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            {w_carry[i], w_sum[i]} = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
    end

    // w_clear marks a cycle whose successor starts from zero phase, with no pulse.
    // This happens on the way into IDLE and on every (re)entry into SETTLE.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_clear    = 1'b0;
        if (!run) begin
            w_next     = IDLE;
            w_cnt_next = '0;
            w_clear    = 1'b1;
        end else if (r_state == IDLE || w_wr_ok) begin
            w_next     = SETTLE;
            w_cnt_next = '0;
            w_clear    = 1'b1;
        end else if (r_state == SETTLE) begin
            w_cnt_next = r_cnt + 1'b1;
            w_next     = (r_cnt == CW'(LOCK_CYCLES - 1)) ? LOCKED : SETTLE;
        end
    end

`ifdef CLKEN_LOCK_GATE_EN
    assign w_clken_next = w_clear ? '0 : (w_carry & {CHANNELS{w_next == LOCKED}});
`else
    assign w_clken_next = w_clear ? '0 : w_carry;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_clken  <= '0;
            r_locked <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
                r_inc[i] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_clken  <= w_clken_next;
            r_locked <= (w_next == LOCKED);
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= w_clear ? '0 : w_sum[i];
                if (w_wr_ok && inc_sel == 4'(i))
                    r_inc[i] <= inc_data;
            end
        end
    end

    assign clken  = r_clken;
    assign locked = r_locked;

endmodule
